seq_alu: RTL and testbench
==========================

SEQ_ALU -- requirements
Module: seq_alu

Interface
REQ-001 SHALL have parameter N, default 32, operand/result width in bits (N >= 4, even).
REQ-002 SHALL have port clk, input, 1, single clock; all state changes on its rising edge.
REQ-003 SHALL have port rst, input, 1, asynchronous active-high reset.
REQ-004 SHALL have port start, input, 1, request to execute ALUop on in0/in1.
REQ-005 SHALL have ports in0 and in1, input, N, operands, sampled only on the accepting edge.
REQ-006 SHALL have port ALUop, input, 4, operation select, sampled only on the accepting edge.
REQ-007 SHALL have port busy, output, 1, high while a multi-cycle operation is in progress.
REQ-008 SHALL have port done, output, 1, one-cycle pulse marking a new valid out.
REQ-009 SHALL have port out, output, N, registered result, held until the next result.
REQ-010 SHALL have port zero, output, 1, combinational ~|out.

Function
REQ-011 SHALL implement states IDLE, MUL, DIV; start is accepted only in IDLE and ignored otherwise.
REQ-012 SHALL complete single-cycle ops on the accepting edge: out updated, done high the following cycle, state stays IDLE.
REQ-013 SHALL decode 0000 add, 0001 sub, 0010 and, 0011 or, 0100 xor (all mod 2^N).
REQ-014 SHALL decode 0110 out=lo, 0111 out=hi, 1000 out=(in0<in1) unsigned, 1001 out=(in0<in1) signed; result zero-extended to N.
REQ-015 SHALL treat every undefined opcode as add.
REQ-016 SHALL start unsigned shift-add multiply on 0101: IDLE->MUL, busy=1, one partial-product step per cycle.
REQ-017 SHALL, on the Nth edge after acceptance, write {hi,lo}=in0*in1 (2N bits), set out=lo, return to IDLE, drop busy, pulse done the next cycle.
REQ-018 SHALL keep hi/lo unchanged by all opcodes other than multiply and divide.
REQ-019 SHALL keep out and done unchanged while busy; done is never high while busy.
REQ-020 SHALL accept start in the cycle done is high (back-to-back operation, no bubble).
REQ-021 SHALL use an internal step counter of ceil(log2(N))+1 bits, cleared on acceptance.

Reset
REQ-022 SHALL, on rst, immediately force IDLE, busy=0, done=0, out=0, hi=0, lo=0, counter=0.
REQ-023 SHALL abandon any in-progress multiply/divide on reset; no result or done follows.
REQ-024 SHALL ignore start while rst is high; first acceptance is on the first edge after rst falls.

Configuration
REQ-025 SHALL, when macro SEQ_ALU_DIV_EN is defined, decode 1010 as unsigned restoring divide: IDLE->DIV, N steps, lo=quotient, hi=remainder, out=lo, timing as REQ-017.
REQ-026 SHALL, for divide by zero with SEQ_ALU_DIV_EN, take the full N cycles and give lo=all ones, hi=in0.
REQ-027 SHALL, when SEQ_ALU_DIV_EN is undefined, omit DIV state and divider logic; 1010 behaves as add.

Verification (bench at N=8)
REQ-028 SHALL check: start, ALUop=0001, in0=5, in1=5 -> out=0, zero=1, done one cycle, busy never high.
REQ-029 SHALL check: ALUop=0101, in0=200, in1=3 -> busy for 8 cycles, then out=88, done; ALUop=0111 -> out=2; ALUop=0110 -> out=88.
REQ-030 SHALL check: ALUop=1000 then 1001 with in0=8'hFF, in1=1 -> out=0 then out=1.
REQ-031 SHALL check: multiply accepted, rst pulsed at step 4 -> busy=0, out=0, hi=lo=0, no done afterwards.
REQ-032 SHALL check: start held during multiply with ALUop=0000 -> ignored; add issued in done cycle -> accepted, result next cycle.
REQ-033 SHALL check with SEQ_ALU_DIV_EN: 1010, in0=100, in1=7 -> lo=14, hi=2 after 8 cycles; in1=0 -> lo=255, hi=100.

Source files
------------

// File: rtl/seq_alu.sv
// Sequential ALU: single-cycle arithmetic/logic/compare ops plus an N-step
// shift-add multiplier and, when SEQ_ALU_DIV_EN is defined, an N-step
// restoring divider. Single-cycle results are written on the accepting edge.
// Multi-cycle results are written on the Nth edge after acceptance.
// done pulses for one cycle after every new result. start is only accepted in IDLE.
// Optional feature macro: SEQ_ALU_DIV_EN (enables opcode 1010 = unsigned divide).
module seq_alu #(
  parameter int N = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [N-1:0] in0,
  input  logic [N-1:0] in1,
  input  logic [3:0]   ALUop,
  output logic         busy,
  output logic         done,
  output logic [N-1:0] out,
  output logic         zero
);

  localparam int CW = $clog2(N) + 1;
  localparam logic [CW-1:0] LAST = CW'(N - 1);

  localparam logic [3:0] OP_SUB  = 4'b0001;
  localparam logic [3:0] OP_AND  = 4'b0010;
  localparam logic [3:0] OP_OR   = 4'b0011;
  localparam logic [3:0] OP_XOR  = 4'b0100;
  localparam logic [3:0] OP_MUL  = 4'b0101;
  localparam logic [3:0] OP_LO   = 4'b0110;
  localparam logic [3:0] OP_HI   = 4'b0111;
  localparam logic [3:0] OP_SLTU = 4'b1000;
  localparam logic [3:0] OP_SLT  = 4'b1001;
`ifdef SEQ_ALU_DIV_EN
  localparam logic [3:0] OP_DIV  = 4'b1010;
`endif

`ifdef SEQ_ALU_DIV_EN
  typedef enum logic [1:0] {IDLE = 2'd0, MUL = 2'd1, DIV = 2'd2} state_t;
`else
  typedef enum logic [1:0] {IDLE = 2'd0, MUL = 2'd1} state_t;
`endif

  state_t          state;
  state_t          state_nxt;
  logic            accept;
  logic            finish;
  logic [CW-1:0]   cnt;
  logic [N-1:0]    hi;
  logic [N-1:0]    lo;
  // Shared iterative register: multiply keeps {partial_hi, multiplier},
  // divide keeps {remainder, dividend/quotient}. opb holds the fixed operand.
  logic [2*N-1:0]  work;
  logic [N-1:0]    opb;
  logic [N-1:0]    alu_res;
  logic [N:0]      mul_sum;
  logic [2*N-1:0]  mul_nxt;

  // One shift-add step: conditionally add multiplicand to the upper half, shift right.
  assign mul_sum = {1'b0, work[2*N-1:N]} + (work[0] ? {1'b0, opb} : {(N+1){1'b0}});
  assign mul_nxt = {mul_sum, work[N-1:1]};

`ifdef SEQ_ALU_DIV_EN
  logic [N:0]      div_trial;
  logic [2*N-1:0]  div_nxt;

  // One restoring step: shift in next dividend bit, keep the subtraction if it did not borrow.
  // A zero divisor never borrows, which yields quotient all-ones and remainder = dividend.
  assign div_trial = work[2*N-1:N-1] - {1'b0, opb};
  assign div_nxt   = div_trial[N] ? {work[2*N-2:0], 1'b0}
                                  : {div_trial[N-1:0], work[N-2:0], 1'b1};
`endif

  assign busy = (state != IDLE);
  assign zero = ~|out;

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Next-state: accept only in IDLE, leave a multi-cycle state after N steps.
  always_comb begin
    state_nxt = state;
    accept    = 1'b0;
    finish    = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          accept = 1'b1;
          if (ALUop == OP_MUL) state_nxt = MUL;
`ifdef SEQ_ALU_DIV_EN
          else if (ALUop == OP_DIV) state_nxt = DIV;
`endif
        end
      end
      MUL: begin
        if (cnt == LAST) begin
          finish    = 1'b1;
          state_nxt = IDLE;
        end
      end
`ifdef SEQ_ALU_DIV_EN
      DIV: begin
        if (cnt == LAST) begin
          finish    = 1'b1;
          state_nxt = IDLE;
        end
      end
`endif
      default: state_nxt = IDLE;
    endcase
  end

  // Single-cycle result selection; undefined opcodes fall through to add.
  always_comb begin
    alu_res = in0 + in1;
    case (ALUop)
      OP_SUB:  alu_res = in0 - in1;
      OP_AND:  alu_res = in0 & in1;
      OP_OR:   alu_res = in0 | in1;
      OP_XOR:  alu_res = in0 ^ in1;
      OP_LO:   alu_res = lo;
      OP_HI:   alu_res = hi;
      OP_SLTU: alu_res = {{(N-1){1'b0}}, (in0 < in1)};
      OP_SLT:  alu_res = {{(N-1){1'b0}}, ($signed(in0) < $signed(in1))};
      default: ;
    endcase
  end

  // Datapath: load operands on acceptance, iterate while busy, publish results with a done pulse.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out  <= '0;
      done <= 1'b0;
      hi   <= '0;
      lo   <= '0;
      cnt  <= '0;
      work <= '0;
      opb  <= '0;
    end else begin
      done <= 1'b0;
      if (accept) begin
        cnt <= '0;
        if (ALUop == OP_MUL) begin
          work <= {{N{1'b0}}, in1};
          opb  <= in0;
        end
`ifdef SEQ_ALU_DIV_EN
        else if (ALUop == OP_DIV) begin
          work <= {{N{1'b0}}, in0};
          opb  <= in1;
        end
`endif
        else begin
          out  <= alu_res;
          done <= 1'b1;
        end
      end else if (state == MUL) begin
        work <= mul_nxt;
        cnt  <= cnt + 1'b1;
        if (finish) begin
          hi   <= mul_nxt[2*N-1:N];
          lo   <= mul_nxt[N-1:0];
          out  <= mul_nxt[N-1:0];
          done <= 1'b1;
        end
      end
`ifdef SEQ_ALU_DIV_EN
      else if (state == DIV) begin
        work <= div_nxt;
        cnt  <= cnt + 1'b1;
        if (finish) begin
          hi   <= div_nxt[2*N-1:N];
          lo   <= div_nxt[N-1:0];
          out  <= div_nxt[N-1:0];
          done <= 1'b1;
        end
      end
`endif
    end
  end

endmodule

// File: tb/tb_seq_alu.sv
// Testbench for seq_alu at N=8: directed scenarios plus randomized ops
// checked against a behavioural model of the operation set and hi/lo state.
module tb_seq_alu;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic [7:0] in0;
  logic [7:0] in1;
  logic [3:0] ALUop;
  logic       busy;
  logic       done;
  logic [7:0] out;
  logic       zero;

  int n_checks = 0;
  int n_fail   = 0;

  logic [7:0] m_hi = 8'h00;
  logic [7:0] m_lo = 8'h00;

  seq_alu #(.N(8)) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .in0   (in0),
    .in1   (in1),
    .ALUop (ALUop),
    .busy  (busy),
    .done  (done),
    .out   (out),
    .zero  (zero)
  );

  always #5 clk = ~clk;

  // Behavioural model: result of one operation, updating the model hi/lo.
  task automatic model(input logic [3:0] op, input logic [7:0] a, input logic [7:0] b,
                       output logic [7:0] r, output bit multi);
    logic [15:0] p;
    multi = 1'b0;
    case (op)
      4'h1: r = a - b;
      4'h2: r = a & b;
      4'h3: r = a | b;
      4'h4: r = a ^ b;
      4'h5: begin
        p = {8'h00, a} * {8'h00, b};
        m_hi = p[15:8];
        m_lo = p[7:0];
        r = m_lo;
        multi = 1'b1;
      end
      4'h6: r = m_lo;
      4'h7: r = m_hi;
      4'h8: r = (a < b) ? 8'd1 : 8'd0;
      4'h9: r = ($signed(a) < $signed(b)) ? 8'd1 : 8'd0;
`ifdef SEQ_ALU_DIV_EN
      4'hA: begin
        if (b == 8'd0) begin
          m_lo = 8'hFF;
          m_hi = a;
        end else begin
          m_lo = a / b;
          m_hi = a % b;
        end
        r = m_lo;
        multi = 1'b1;
      end
`endif
      default: r = a + b;
    endcase
  endtask

  // Drive one request and wait (bounded) until done is seen; reports busy cycles.
  task automatic run_op(input logic [3:0] op, input logic [7:0] a, input logic [7:0] b,
                        output int bcyc, output bit ok);
    @(negedge clk);
    start = 1'b1;
    ALUop = op;
    in0   = a;
    in1   = b;
    @(posedge clk);
    #1;
    start = 1'b0;
    in0   = 8'($urandom);
    in1   = 8'($urandom);
    ALUop = 4'($urandom);
    bcyc  = 0;
    ok    = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if (done) begin
        ok = 1'b1;
        break;
      end
      if (busy) bcyc++;
      @(posedge clk);
      #1;
    end
  endtask

  task automatic test_reset;
    rst   = 1'b1;
    start = 1'b1;
    ALUop = 4'h0;
    in0   = 8'd3;
    in1   = 8'd4;
    repeat (3) @(posedge clk);
    #1;
    n_checks++;
    if (busy !== 1'b0 || done !== 1'b0 || out !== 8'd0 || zero !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_state: busy=%b done=%b out=%0d zero=%b, want 0 0 0 1", busy, done, out, zero);
    end
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    start = 1'b0;
    n_checks++;
    if (done !== 1'b1 || out !== 8'd7) begin
      n_fail++;
      $display("FAIL first_accept_after_reset: done=%b out=%0d, want 1 7", done, out);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_sub_zero;
    int bcyc;
    bit ok;
    run_op(4'h1, 8'd5, 8'd5, bcyc, ok);
    n_checks++;
    if (!ok || bcyc !== 0 || out !== 8'd0 || zero !== 1'b1) begin
      n_fail++;
      $display("FAIL sub_zero: ok=%b busy_cycles=%0d out=%0d zero=%b, want 1 0 0 1", ok, bcyc, out, zero);
    end
    @(posedge clk);
    #1;
    n_checks++;
    if (done !== 1'b0) begin
      n_fail++;
      $display("FAIL done_pulse_width: done=%b, want 0", done);
    end
  endtask

  task automatic test_mul;
    int bcyc;
    bit ok;
    logic [7:0] r;
    bit multi;
    model(4'h5, 8'd200, 8'd3, r, multi);
    run_op(4'h5, 8'd200, 8'd3, bcyc, ok);
    n_checks++;
    if (!ok || bcyc !== 8 || out !== 8'd88 || r !== 8'd88) begin
      n_fail++;
      $display("FAIL mul_200x3: ok=%b busy_cycles=%0d out=%0d, want 1 8 88", ok, bcyc, out);
    end
    model(4'h7, 8'd0, 8'd0, r, multi);
    run_op(4'h7, 8'd9, 8'd9, bcyc, ok);
    n_checks++;
    if (!ok || out !== 8'd2 || out !== r) begin
      n_fail++;
      $display("FAIL mul_hi: ok=%b out=%0d, want 2", ok, out);
    end
    model(4'h6, 8'd0, 8'd0, r, multi);
    run_op(4'h6, 8'd1, 8'd1, bcyc, ok);
    n_checks++;
    if (!ok || out !== 8'd88 || out !== r) begin
      n_fail++;
      $display("FAIL mul_lo: ok=%b out=%0d, want 88", ok, out);
    end
  endtask

  task automatic test_compare;
    int bcyc;
    bit ok;
    run_op(4'h8, 8'hFF, 8'd1, bcyc, ok);
    n_checks++;
    if (!ok || out !== 8'd0) begin
      n_fail++;
      $display("FAIL sltu_ff_1: ok=%b out=%0d, want 0", ok, out);
    end
    run_op(4'h9, 8'hFF, 8'd1, bcyc, ok);
    n_checks++;
    if (!ok || out !== 8'd1) begin
      n_fail++;
      $display("FAIL slt_ff_1: ok=%b out=%0d, want 1", ok, out);
    end
  endtask

  task automatic test_reset_mid_mul;
    int bcyc;
    bit ok;
    bit seen;
    logic [7:0] r;
    bit multi;
    @(negedge clk);
    start = 1'b1;
    ALUop = 4'h5;
    in0   = 8'd77;
    in1   = 8'd13;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (3) @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    n_checks++;
    if (busy !== 1'b0 || done !== 1'b0 || out !== 8'd0) begin
      n_fail++;
      $display("FAIL reset_mid_mul: busy=%b done=%b out=%0d, want 0 0 0", busy, done, out);
    end
    @(negedge clk);
    rst = 1'b0;
    m_hi = 8'h00;
    m_lo = 8'h00;
    seen = 1'b0;
    repeat (12) begin
      @(posedge clk);
      #1;
      if (done || busy) seen = 1'b1;
    end
    n_checks++;
    if (seen !== 1'b0) begin
      n_fail++;
      $display("FAIL abandoned_mul_activity: seen=%b, want 0", seen);
    end
    model(4'h7, 8'd0, 8'd0, r, multi);
    run_op(4'h7, 8'd0, 8'd0, bcyc, ok);
    n_checks++;
    if (!ok || out !== r) begin
      n_fail++;
      $display("FAIL hi_after_reset: out=%0d, want %0d", out, r);
    end
    model(4'h6, 8'd0, 8'd0, r, multi);
    run_op(4'h6, 8'd0, 8'd0, bcyc, ok);
    n_checks++;
    if (!ok || out !== r) begin
      n_fail++;
      $display("FAIL lo_after_reset: out=%0d, want %0d", out, r);
    end
  endtask

  task automatic test_back_to_back;
    logic [7:0] r;
    logic [7:0] held;
    bit multi;
    int bcyc;
    int bad;
    bit ok;
    held = out;
    model(4'h5, 8'd25, 8'd11, r, multi);
    @(negedge clk);
    start = 1'b1;
    ALUop = 4'h5;
    in0   = 8'd25;
    in1   = 8'd11;
    @(posedge clk);
    #1;
    ALUop = 4'h0;
    in0   = 8'd40;
    in1   = 8'd2;
    bcyc  = 0;
    bad   = 0;
    ok    = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if (done) begin
        ok = 1'b1;
        break;
      end
      if (busy) bcyc++;
      if (out !== held) bad++;
      @(posedge clk);
      #1;
    end
    n_checks++;
    if (!ok || bcyc !== 8 || bad !== 0 || out !== r) begin
      n_fail++;
      $display("FAIL start_held_during_mul: ok=%b busy_cycles=%0d out_changes=%0d out=%0d, want 1 8 0 %0d",
               ok, bcyc, bad, out, r);
    end
    @(posedge clk);
    #1;
    start = 1'b0;
    n_checks++;
    if (done !== 1'b1 || busy !== 1'b0 || out !== 8'd42) begin
      n_fail++;
      $display("FAIL add_in_done_cycle: done=%b busy=%b out=%0d, want 1 0 42", done, busy, out);
    end
  endtask

  task automatic test_random;
    logic [3:0] op;
    logic [7:0] a;
    logic [7:0] b;
    logic [7:0] r;
    bit multi;
    int bcyc;
    bit ok;
    for (int k = 0; k < 40; k++) begin
      op = 4'($urandom_range(0, 15));
      a  = 8'($urandom);
      b  = 8'($urandom);
      model(op, a, b, r, multi);
      run_op(op, a, b, bcyc, ok);
      n_checks++;
      if (!ok || out !== r || zero !== (r == 8'd0) || bcyc !== (multi ? 8 : 0)) begin
        n_fail++;
        $display("FAIL random op=%h a=%0d b=%0d: ok=%b out=%0d zero=%b busy_cycles=%0d, want out=%0d busy_cycles=%0d",
                 op, a, b, ok, out, zero, bcyc, r, multi ? 8 : 0);
      end
    end
  endtask

`ifdef SEQ_ALU_DIV_EN
  task automatic test_div;
    int bcyc;
    bit ok;
    run_op(4'hA, 8'd100, 8'd7, bcyc, ok);
    n_checks++;
    if (!ok || bcyc !== 8 || out !== 8'd14) begin
      n_fail++;
      $display("FAIL div_100_7: ok=%b busy_cycles=%0d out=%0d, want 1 8 14", ok, bcyc, out);
    end
    run_op(4'h7, 8'd0, 8'd0, bcyc, ok);
    n_checks++;
    if (!ok || out !== 8'd2) begin
      n_fail++;
      $display("FAIL div_rem: out=%0d, want 2", out);
    end
    run_op(4'hA, 8'd100, 8'd0, bcyc, ok);
    n_checks++;
    if (!ok || bcyc !== 8 || out !== 8'd255) begin
      n_fail++;
      $display("FAIL div_by_zero: ok=%b busy_cycles=%0d out=%0d, want 1 8 255", ok, bcyc, out);
    end
    run_op(4'h7, 8'd0, 8'd0, bcyc, ok);
    n_checks++;
    if (!ok || out !== 8'd100) begin
      n_fail++;
      $display("FAIL div_by_zero_hi: out=%0d, want 100", out);
    end
    m_lo = 8'hFF;
    m_hi = 8'd100;
  endtask
`else
  task automatic test_div;
    int bcyc;
    bit ok;
    run_op(4'hA, 8'd100, 8'd7, bcyc, ok);
    n_checks++;
    if (!ok || bcyc !== 0 || out !== 8'd107) begin
      n_fail++;
      $display("FAIL op1010_as_add: ok=%b busy_cycles=%0d out=%0d, want 1 0 107", ok, bcyc, out);
    end
  endtask
`endif

  initial begin
    rst   = 1'b1;
    start = 1'b0;
    ALUop = 4'h0;
    in0   = 8'd0;
    in1   = 8'd0;
    test_reset;
    test_sub_zero;
    test_mul;
    test_compare;
    test_reset_mid_mul;
    test_back_to_back;
    test_div;
    test_random;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
